// File: rtl/byte_packer_sv.sv
// byte_packer_sv: packs a little-endian stream of bytes into BYTES*8-bit words.
// A flush emits a partially filled word with zeros above the last valid byte.
module byte_packer_sv #(
  parameter int unsigned BYTES = 4,
  parameter int unsigned CW    = $clog2(BYTES + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               flush,
  output logic [BYTES*8-1:0] out_data,
  output logic [CW-1:0]      out_bytes,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned W = BYTES * 8;

  typedef enum logic {FILL, FULL} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  merged;
  logic          byte_hs;
  logic          word_hs;
  logic          flush_eff;
  logic          emit;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nx;
  end

  // Next state: a completing word wins over retiring the held one
  always_comb begin
    state_nx = state;
    if (emit)         state_nx = FULL;
    else if (word_hs) state_nx = FILL;
  end

  // Outputs: a held word blocks input unless it retires this cycle
  always_comb begin
    out_valid = (state == FULL);
    in_ready  = !out_valid || out_ready;
  end

  // Handshakes, emit decision and accumulator with the incoming byte merged in.
  // acc is zero above cnt, so merged is directly usable as a flushed word.
  always_comb begin
    byte_hs   = in_valid && in_ready;
    word_hs   = out_valid && out_ready;
    flush_eff = flush && in_ready;
    emit      = (byte_hs && (cnt == CW'(BYTES - 1))) ||
                (flush_eff && (byte_hs || (cnt != '0)));
    merged    = acc;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (byte_hs && (cnt == CW'(i))) merged[i*8 +: 8] = in_data;
    end
  end

  // Datapath: fill counter, accumulator and held output word
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      out_data  <= '0;
      out_bytes <= '0;
    end else if (emit) begin
      out_data  <= merged;
      out_bytes <= byte_hs ? cnt + CW'(1) : cnt;
      cnt       <= '0;
      acc       <= '0;
    end else if (byte_hs) begin
      acc <= merged;
      cnt <= cnt + CW'(1);
    end
  end

endmodule
